// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states and per-register stall/flush bundle.
// Used by hazard_ctrl and hazard_ldu_detect.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_CTRL_NONE = '0;

endpackage

// File: rtl/hazard_ldu_detect.sv
// Load-use detector: EX load writes a register the ID instruction reads.
// Ports: i_rs1/i_rs2/i_use_rs1/i_use_rs2 (ID), i_rd/i_is_load (EX), o_hit.
module hazard_ldu_detect import pipeline_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_use_rs1,
  input  logic              i_use_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_is_load,
  output logic              o_hit
);

  logic w_rd_nz;
  logic w_m1;
  logic w_m2;

  // x0 is hardwired zero, so a load to it never creates a dependency
  assign w_rd_nz = |i_rd;
  assign w_m1    = i_use_rs1 && (i_rs1 == i_rd);
  assign w_m2    = i_use_rs2 && (i_rs2 == i_rd);
  assign o_hit   = i_is_load && w_rd_nz && (w_m1 || w_m2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush per stage, mul/div and dmem waits.
// Ports: clk_i, rst_i (sync, active-high), ID/EX operand info, hazard inputs,
// per-register stall/flush outputs, md_kill_o, state_o, perf counters.
// Optional: define HAZARD_PERF_CNT_EN to build stall/flush counters.
module hazard_ctrl import pipeline_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_redirect_i,
  input  logic              ex_md_start_i,
  input  logic              md_busy_i,
  input  logic              mem_stall_i,
  input  logic              if_stall_i,
  input  logic              trap_i,
  output logic              pc_stall_o,
  output logic              md_kill_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_stall_o,
  output logic              idex_flush_o,
  output logic              exmem_stall_o,
  output logic              exmem_flush_o,
  output logic              memwb_stall_o,
  output logic              memwb_flush_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  hz_state_e  r_state;
  hz_state_e  w_next;
  pipe_ctrl_t w_ctl;
  logic       w_kill;
  logic       w_ldu;

  hazard_ldu_detect #(
    .REG_AW(REG_AW)
  ) u_ldu (
    .i_rs1    (id_rs1_i),
    .i_rs2    (id_rs2_i),
    .i_use_rs1(id_use_rs1_i),
    .i_use_rs2(id_use_rs2_i),
    .i_rd     (ex_rd_i),
    .i_is_load(ex_is_load_i),
    .o_hit    (w_ldu)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RUN;
    else       r_state <= w_next;
  end

  // MEM_WAIT only records that dmem was stalling; once it clears the
  // cycle is decoded exactly like RUN.
  always_comb begin
    w_ctl  = PIPE_CTRL_NONE;
    w_kill = 1'b0;
    w_next = r_state;
    if (rst_i) begin
      w_next = RUN;
    end else if (mem_stall_i) begin
      w_ctl.pc_stall    = 1'b1;
      w_ctl.ifid_stall  = 1'b1;
      w_ctl.idex_stall  = 1'b1;
      w_ctl.exmem_stall = 1'b1;
      w_ctl.memwb_flush = 1'b1;
      w_next            = MEM_WAIT;
    end else if (trap_i) begin
      w_ctl.ifid_flush  = 1'b1;
      w_ctl.idex_flush  = 1'b1;
      w_ctl.exmem_flush = 1'b1;
      w_kill            = (r_state == MD_WAIT);
      w_next            = RUN;
    end else if (r_state == MD_WAIT) begin
      if (md_busy_i) begin
        w_ctl.pc_stall    = 1'b1;
        w_ctl.ifid_stall  = 1'b1;
        w_ctl.idex_stall  = 1'b1;
        w_ctl.exmem_flush = 1'b1;
        w_next            = MD_WAIT;
      end else begin
        w_next = RUN;
      end
    end else begin
      w_next = ex_md_start_i ? MD_WAIT : RUN;
      if (ex_redirect_i) begin
        w_ctl.ifid_flush = 1'b1;
        w_ctl.idex_flush = 1'b1;
      end else if (w_ldu) begin
        w_ctl.pc_stall   = 1'b1;
        w_ctl.ifid_stall = 1'b1;
        w_ctl.idex_flush = 1'b1;
      end else if (if_stall_i) begin
        w_ctl.pc_stall   = 1'b1;
        w_ctl.ifid_flush = 1'b1;
      end
    end
  end

  assign pc_stall_o    = w_ctl.pc_stall;
  assign ifid_stall_o  = w_ctl.ifid_stall;
  assign ifid_flush_o  = w_ctl.ifid_flush;
  assign idex_stall_o  = w_ctl.idex_stall;
  assign idex_flush_o  = w_ctl.idex_flush;
  assign exmem_stall_o = w_ctl.exmem_stall;
  assign exmem_flush_o = w_ctl.exmem_flush;
  assign memwb_stall_o = w_ctl.memwb_stall;
  assign memwb_flush_o = w_ctl.memwb_flush;
  assign md_kill_o     = w_kill;
  assign state_o       = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ctl.pc_stall)   r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_ctl.idex_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
